// File: rtl/freq_divider.sv
// Programmable integer divider: ClkOutput is a registered square wave with a
// period of DivReg Clk cycles, high for ceil(N/2) cycles and low for the rest.
module freq_divider #(
    parameter int DIN_WIDTH = 32,
    parameter int MIN_DIV   = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DIN_WIDTH-1:0] Din,
    input  logic                 ConfigDiv,
    input  logic                 Enable,
    output logic                 ClkOutput
);

    localparam logic [DIN_WIDTH-1:0] MIN_DIV_V = DIN_WIDTH'(MIN_DIV);
    localparam logic [DIN_WIDTH-1:0] ONE_V     = {{(DIN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIN_WIDTH-1:0] ZERO_V    = {DIN_WIDTH{1'b0}};

    // Replace any divisor below the legal minimum with the minimum.
    function automatic logic [DIN_WIDTH-1:0] clamp_div(input logic [DIN_WIDTH-1:0] d);
        if (d < MIN_DIV_V) begin
            return MIN_DIV_V;
        end else begin
            return d;
        end
    endfunction

    // ceil(n/2) with one extra bit so n = all-ones cannot overflow.
    function automatic logic [DIN_WIDTH:0] half_ceil(input logic [DIN_WIDTH-1:0] n);
        logic [DIN_WIDTH:0] sum;
        sum = {1'b0, n} + {{DIN_WIDTH{1'b0}}, 1'b1};
        return sum >> 1;
    endfunction

    logic [DIN_WIDTH-1:0] div_r;
    logic [DIN_WIDTH-1:0] cnt_r;
    logic                 out_r;

    logic [DIN_WIDTH-1:0] div_nxt_s;
    logic [DIN_WIDTH-1:0] cnt_nxt_s;
    logic                 out_nxt_s;
    logic [DIN_WIDTH:0]   half_s;
    logic                 cnt_wrap_s;
    logic                 high_phase_s;

    // Phase decode: high while Cnt is in the first ceil(N/2) slots of the period.
    always_comb begin
        half_s       = half_ceil(div_r);
        cnt_wrap_s   = (cnt_r == (div_r - ONE_V));
        high_phase_s = ({1'b0, cnt_r} < half_s);
    end

    // Next-state selection: config beats enable, disable clears the phase.
    always_comb begin
        div_nxt_s = div_r;
        cnt_nxt_s = cnt_r;
        out_nxt_s = out_r;
        case ({ConfigDiv, Enable})
            2'b10, 2'b11: begin
                div_nxt_s = clamp_div(Din);
                cnt_nxt_s = ZERO_V;
                out_nxt_s = 1'b0;
            end
            2'b01: begin
                out_nxt_s = high_phase_s;
                if (cnt_wrap_s) begin
                    cnt_nxt_s = ZERO_V;
                end else begin
                    cnt_nxt_s = cnt_r + ONE_V;
                end
            end
            2'b00: begin
                cnt_nxt_s = ZERO_V;
                out_nxt_s = 1'b0;
            end
            default: begin
                cnt_nxt_s = ZERO_V;
                out_nxt_s = 1'b0;
            end
        endcase
    end

    // State registers; reset restores the minimum divisor and a low output.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_r <= MIN_DIV_V;
            cnt_r <= ZERO_V;
            out_r <= 1'b0;
        end else begin
            div_r <= div_nxt_s;
            cnt_r <= cnt_nxt_s;
            out_r <= out_nxt_s;
        end
    end

    assign ClkOutput = out_r;

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider: each task drives one scenario and checks
// ClkOutput against hand-written expected patterns, sampled 1 ns after posedge.
module tb_freq_divider;

    logic        Clk;
    logic        Reset;
    logic [31:0] Din;
    logic        ConfigDiv;
    logic        Enable;
    logic        ClkOutput;

    int errors;
    int checks;

    freq_divider #(.DIN_WIDTH(32), .MIN_DIV(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Din       (Din),
        .ConfigDiv (ConfigDiv),
        .Enable    (Enable),
        .ClkOutput (ClkOutput)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_config(input logic [31:0] d, input logic en);
        Din       = d;
        ConfigDiv = 1'b1;
        Enable    = en;
        tick();
        checks++;
        if (ClkOutput !== 1'b0) begin
            errors++;
            $display("FAIL config_edge_low din=%0d: got %b expected 0", d, ClkOutput);
        end
        ConfigDiv = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] pat;
        pat = 4'b1010;
        Reset = 1'b0; Enable = 1'b0; ConfigDiv = 1'b0; Din = 32'd0;
        tick();
        tick();
        checks++;
        if (ClkOutput !== 1'b0) begin
            errors++;
            $display("FAIL reset_low: got %b expected 0", ClkOutput);
        end
        #2;
        Reset  = 1'b1;
        Enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[3-i]) begin
                errors++;
                $display("FAIL reset_n2 step %0d: got %b expected %b", i, ClkOutput, pat[3-i]);
            end
        end
    endtask

    task automatic test_div5();
        logic [9:0] pat;
        pat = 10'b11100_11100;
        do_config(32'd5, 1'b0);
        Enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[9-i]) begin
                errors++;
                $display("FAIL div5 step %0d: got %b expected %b", i, ClkOutput, pat[9-i]);
            end
        end
    endtask

    task automatic test_div4();
        logic [7:0] pat;
        pat = 8'b1100_1100;
        do_config(32'd4, 1'b0);
        Enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[7-i]) begin
                errors++;
                $display("FAIL div4 step %0d: got %b expected %b", i, ClkOutput, pat[7-i]);
            end
        end
    endtask

    task automatic test_small_div();
        logic [3:0] pat;
        pat = 4'b1010;
        for (int d = 0; d < 2; d++) begin
            do_config(32'(d), 1'b1);
            Enable = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (ClkOutput !== pat[3-i]) begin
                    errors++;
                    $display("FAIL small_div din=%0d step %0d: got %b expected %b",
                             d, i, ClkOutput, pat[3-i]);
                end
            end
        end
    endtask

    task automatic test_disable();
        logic [4:0] pat;
        pat = 5'b11100;
        do_config(32'd5, 1'b0);
        Enable = 1'b1;
        tick();
        tick();
        checks++;
        if (ClkOutput !== 1'b1) begin
            errors++;
            $display("FAIL disable_pre_high: got %b expected 1", ClkOutput);
        end
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ClkOutput !== 1'b0) begin
                errors++;
                $display("FAIL disable_low step %0d: got %b expected 0", i, ClkOutput);
            end
        end
        Enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[4-i]) begin
                errors++;
                $display("FAIL reenable step %0d: got %b expected %b", i, ClkOutput, pat[4-i]);
            end
        end
    endtask

    task automatic test_reconfig_running();
        logic [5:0] pat;
        pat = 6'b110110;
        do_config(32'd5, 1'b0);
        Enable = 1'b1;
        tick();
        tick();
        do_config(32'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[5-i]) begin
                errors++;
                $display("FAIL reconfig3 step %0d: got %b expected %b", i, ClkOutput, pat[5-i]);
            end
        end
        Din = 32'd7;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[5-i]) begin
                errors++;
                $display("FAIL din_ignored step %0d: got %b expected %b", i, ClkOutput, pat[5-i]);
            end
        end
    endtask

    task automatic test_config_hold();
        logic [3:0] pat;
        pat = 4'b1100;
        Enable    = 1'b1;
        Din       = 32'd4;
        ConfigDiv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ClkOutput !== 1'b0) begin
                errors++;
                $display("FAIL config_hold step %0d: got %b expected 0", i, ClkOutput);
            end
        end
        ConfigDiv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[3-i]) begin
                errors++;
                $display("FAIL after_hold step %0d: got %b expected %b", i, ClkOutput, pat[3-i]);
            end
        end
    endtask

    task automatic test_max_div();
        do_config(32'hFFFF_FFFF, 1'b0);
        Enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (ClkOutput !== 1'b1) begin
                errors++;
                $display("FAIL max_div step %0d: got %b expected 1", i, ClkOutput);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] pat;
        pat = 4'b1010;
        do_config(32'd5, 1'b0);
        Enable = 1'b1;
        tick();
        checks++;
        if (ClkOutput !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_high: got %b expected 1", ClkOutput);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (ClkOutput !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b expected 0", ClkOutput);
        end
        #2;
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ClkOutput !== pat[3-i]) begin
                errors++;
                $display("FAIL post_reset_n2 step %0d: got %b expected %b", i, ClkOutput, pat[3-i]);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        Reset     = 1'b0;
        Din       = 32'd0;
        ConfigDiv = 1'b0;
        Enable    = 1'b0;
        test_reset();
        test_div5();
        test_div4();
        test_small_div();
        test_disable();
        test_reconfig_running();
        test_config_hold();
        test_max_div();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
